// File: rtl/waveform_symbol_mapper.sv
// -----------------------------------------------------------------------------
// waveform_symbol_mapper
//
// Maps each incoming symbol of BITS_PER_SYM bits onto a stored waveform of SPS
// samples and streams those samples out over a valid/ready interface. The
// waveform LUT holds 2^BITS_PER_SYM waveforms of SPS samples each and is
// written through a simple strobe port while the mapper is idle. One instance
// per I/Q channel, between the frame RAM reader and the DAC/filter chain.
//
// Ports:
//   clk        sole clock, all logic on posedge
//   reset      synchronous, active-high
//   in_valid   in_bits carries a symbol
//   in_ready   mapper accepts in_bits this cycle (combinational)
//   in_bits    symbol value
//   out_valid  out_data carries a sample
//   out_ready  downstream accepts out_data
//   out_data   waveform sample
//   out_sof    out_data is sample 0 of a symbol
//   out_eos    out_data is sample SPS-1 of a symbol
//   underrun   one-cycle pulse: a symbol ended with no successor waiting
//   lut_we     LUT write strobe
//   lut_addr   LUT write address {symbol, sample}
//   lut_wdata  LUT write data
//   lut_busy   mapper is streaming; LUT writes are dropped while high
//
// The LUT has no preload path in this implementation; its contents are
// expected to be loaded through lut_we before traffic starts. INIT_FILE is
// kept so existing instantiations remain parameter-compatible.
// -----------------------------------------------------------------------------
module waveform_symbol_mapper #(
  parameter int    DATA_W       = 16,
  parameter int    BITS_PER_SYM = 1,
  parameter int    SPS          = 8,
  parameter string INIT_FILE    = "",
  localparam int   CNT_W        = $clog2(SPS),
  localparam int   AW           = BITS_PER_SYM + CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BITS_PER_SYM-1:0] in_bits,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_sof,
  output logic                    out_eos,
  output logic                    underrun,
  input  logic                    lut_we,
  input  logic [AW-1:0]           lut_addr,
  input  logic [DATA_W-1:0]       lut_wdata,
  output logic                    lut_busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SPS - 1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BITS_PER_SYM-1:0] sym_q, sym_d;
  logic                    out_valid_d;
  logic [DATA_W-1:0]       out_data_d;
  logic                    out_sof_d;
  logic                    out_eos_d;
  logic                    underrun_d;

  logic [DATA_W-1:0]       lut [2**AW];

  logic adv;
  logic last_sample;

  // The output register may move whenever it is empty or being drained.
  assign adv         = !out_valid || out_ready;
  assign last_sample = (cnt_q == LAST_CNT);
  assign in_ready    = adv && ((state_q == S_IDLE) || last_sample);
  assign lut_busy    = (state_q == S_RUN) || out_valid;

  // NOTE: the LUT has no reset branch; clearing a RAM on reset would force it
  // into flops and the waveforms must survive a channel reset anyway.
  always_ff @(posedge clk) begin
    if (lut_we && !lut_busy) begin
      lut[lut_addr] <= lut_wdata;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    sym_d       = sym_q;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_sof_d   = out_sof;
    out_eos_d   = out_eos;
    // underrun is a strobe, not pipeline state: it clears even under a stall.
    underrun_d  = 1'b0;

    if (adv) begin
      unique case (state_q)
        S_IDLE: begin
          out_valid_d = 1'b0;
          if (in_valid) begin
            sym_d   = in_bits;
            cnt_d   = '0;
            state_d = S_RUN;
          end
        end

        S_RUN: begin
          // The read at {sym,cnt} lands in out_data at this edge, so the
          // LUT read is effectively synchronous through the output register.
          out_valid_d = 1'b1;
          out_data_d  = lut[{sym_q, cnt_q}];
          out_sof_d   = (cnt_q == '0);
          out_eos_d   = last_sample;
          if (!last_sample) begin
            cnt_d = cnt_q + 1'b1;
          end else if (in_valid) begin
            // Successor taken on the last sample keeps the stream gapless.
            sym_d = in_bits;
            cnt_d = '0;
          end else begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            underrun_d = 1'b1;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sym_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      out_eos   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sym_q     <= sym_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_sof   <= out_sof_d;
      out_eos   <= out_eos_d;
      underrun  <= underrun_d;
    end
  end

endmodule

// File: tb/tb_waveform_symbol_mapper.sv
// -----------------------------------------------------------------------------
// tb_waveform_symbol_mapper
//
// Directed bench for waveform_symbol_mapper. Instance u_dut uses
// DATA_W=16, BITS_PER_SYM=1, SPS=8 with LUT[0..7]=0x0000..0x0007 and
// LUT[8..15]=0x1000..0x1007. Instance u_dut2 uses BITS_PER_SYM=2, SPS=4 with
// LUT[a]=a. Inputs change 1 time unit after each rising edge and outputs are
// sampled at that same point.
// -----------------------------------------------------------------------------
module tb_waveform_symbol_mapper;

  logic        clk = 1'b0;
  logic        reset;

  // Instance 1: BITS_PER_SYM=1, SPS=8
  logic        in_valid, in_ready;
  logic [0:0]  in_bits;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic        out_sof, out_eos, underrun;
  logic        lut_we;
  logic [3:0]  lut_addr;
  logic [15:0] lut_wdata;
  logic        lut_busy;

  // Instance 2: BITS_PER_SYM=2, SPS=4
  logic        in_valid2, in_ready2;
  logic [1:0]  in_bits2;
  logic        out_valid2, out_ready2;
  logic [15:0] out_data2;
  logic        out_sof2, out_eos2, underrun2;
  logic        lut_we2;
  logic [3:0]  lut_addr2;
  logic [15:0] lut_wdata2;
  logic        lut_busy2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  waveform_symbol_mapper #(
    .DATA_W(16), .BITS_PER_SYM(1), .SPS(8)
  ) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sof(out_sof), .out_eos(out_eos), .underrun(underrun),
    .lut_we(lut_we), .lut_addr(lut_addr), .lut_wdata(lut_wdata),
    .lut_busy(lut_busy)
  );

  waveform_symbol_mapper #(
    .DATA_W(16), .BITS_PER_SYM(2), .SPS(4)
  ) u_dut2 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_bits(in_bits2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .out_sof(out_sof2), .out_eos(out_eos2), .underrun(underrun2),
    .lut_we(lut_we2), .lut_addr(lut_addr2), .lut_wdata(lut_wdata2),
    .lut_busy(lut_busy2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Accept one symbol from idle and check all 8 samples, then the idle cycle.
  task automatic run_symbol(input logic b, input logic [15:0] base);
    in_valid = 1'b1;
    in_bits  = b;
    chk("sym_accept_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("sym_first_not_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("sym_valid", 32'(out_valid), 32'd1);
      chk("sym_data", 32'(out_data), 32'(base + 16'(i)));
      chk("sym_sof", 32'(out_sof), 32'(i == 0));
      chk("sym_eos", 32'(out_eos), 32'(i == 7));
      chk("sym_underrun", 32'(underrun), 32'(i == 7));
    end
    step();
    chk("sym_idle_valid", 32'(out_valid), 32'd0);
    chk("sym_idle_underrun", 32'(underrun), 32'd0);
  endtask

  logic [15:0] exp_b2b;
  logic [15:0] exp_v2 [8];

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_bits    = '0;
    out_ready  = 1'b1;
    lut_we     = 1'b0;
    lut_addr   = '0;
    lut_wdata  = '0;
    in_valid2  = 1'b0;
    in_bits2   = '0;
    out_ready2 = 1'b1;
    lut_we2    = 1'b0;
    lut_addr2  = '0;
    lut_wdata2 = '0;

    // ---- reset state ----
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sof", 32'(out_sof), 32'd0);
    chk("rst_out_eos", 32'(out_eos), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_lut_busy", 32'(lut_busy), 32'd0);
    reset = 1'b0;

    // ---- LUT load for both instances ----
    for (int i = 0; i < 16; i++) begin
      lut_we     = 1'b1;
      lut_addr   = 4'(i);
      lut_wdata  = (i < 8) ? 16'(i) : 16'(16'h1000 + 16'(i - 8));
      lut_we2    = 1'b1;
      lut_addr2  = 4'(i);
      lut_wdata2 = 16'(i);
      step();
    end
    lut_we  = 1'b0;
    lut_we2 = 1'b0;

    // ---- 1. back-to-back symbols 1 then 0 ----
    in_valid = 1'b1;
    in_bits  = 1'b1;
    chk("b2b_ready_first", 32'(in_ready), 32'd1);
    step();
    in_bits = 1'b0;
    chk("b2b_ready_after_accept", 32'(in_ready), 32'd0);
    for (int i = 0; i < 16; i++) begin
      step();
      exp_b2b = (i < 8) ? 16'(16'h1000 + 16'(i)) : 16'(i - 8);
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk("b2b_data", 32'(out_data), 32'(exp_b2b));
      chk("b2b_sof", 32'(out_sof), 32'((i % 8) == 0));
      chk("b2b_eos", 32'(out_eos), 32'((i % 8) == 7));
      chk("b2b_underrun", 32'(underrun), 32'(i == 15));
      chk("b2b_in_ready", 32'(in_ready), 32'(((i % 8) == 6) || (i == 15)));
      if (i == 7) in_valid = 1'b0;
    end
    step();
    chk("b2b_end_valid", 32'(out_valid), 32'd0);
    chk("b2b_end_underrun", 32'(underrun), 32'd0);

    // ---- 2. backpressure on sample 0x1003 ----
    in_valid = 1'b1;
    in_bits  = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_pre_data", 32'(out_data), 32'(16'h1000 + 16'(i)));
    end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_data", 32'(out_data), 32'h1003);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_sof", 32'(out_sof), 32'd0);
      chk("bp_hold_eos", 32'(out_eos), 32'd0);
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_busy", 32'(lut_busy), 32'd1);
      if (i < 2) step();
    end
    out_ready = 1'b1;
    for (int i = 4; i < 8; i++) begin
      step();
      chk("bp_post_data", 32'(out_data), 32'(16'h1000 + 16'(i)));
      chk("bp_post_eos", 32'(out_eos), 32'(i == 7));
      chk("bp_post_underrun", 32'(underrun), 32'(i == 7));
    end
    step();
    chk("bp_end_valid", 32'(out_valid), 32'd0);

    // ---- 3. starvation then late symbol 0 ----
    step();
    step();
    chk("starve_idle_valid", 32'(out_valid), 32'd0);
    chk("starve_idle_underrun", 32'(underrun), 32'd0);
    run_symbol(1'b0, 16'h0000);

    // ---- 4. LUT write while busy is dropped ----
    in_valid = 1'b1;
    in_bits  = 1'b0;
    step();
    in_valid  = 1'b0;
    lut_we    = 1'b1;
    lut_addr  = 4'd3;
    lut_wdata = 16'hBEEF;
    chk("busy_flag", 32'(lut_busy), 32'd1);
    step();
    lut_we = 1'b0;
    for (int i = 1; i < 8; i++) step();
    chk("busy_sym_last", 32'(out_data), 32'h0007);
    step();
    chk("busy_idle_flag", 32'(lut_busy), 32'd0);
    run_symbol(1'b0, 16'h0000);

    // ---- 5. reset mid-symbol, then reset together with in_valid ----
    in_valid = 1'b1;
    in_bits  = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("midrst_pre_data", 32'(out_data), 32'h1004);
    reset = 1'b1;
    step();
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_data", 32'(out_data), 32'd0);
    chk("midrst_underrun", 32'(underrun), 32'd0);
    chk("midrst_busy", 32'(lut_busy), 32'd0);
    in_valid = 1'b1;
    in_bits  = 1'b1;
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    step();
    chk("rst_wins_valid", 32'(out_valid), 32'd0);
    chk("rst_wins_busy", 32'(lut_busy), 32'd0);
    run_symbol(1'b1, 16'h1000);
    run_symbol(1'b0, 16'h0000);

    // ---- 6. BITS_PER_SYM=2, SPS=4: symbols 3 then 2 ----
    exp_v2[0] = 16'd12; exp_v2[1] = 16'd13; exp_v2[2] = 16'd14; exp_v2[3] = 16'd15;
    exp_v2[4] = 16'd8;  exp_v2[5] = 16'd9;  exp_v2[6] = 16'd10; exp_v2[7] = 16'd11;
    in_valid2 = 1'b1;
    in_bits2  = 2'd3;
    chk("v2_ready_first", 32'(in_ready2), 32'd1);
    step();
    in_bits2 = 2'd2;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("v2_valid", 32'(out_valid2), 32'd1);
      chk("v2_data", 32'(out_data2), 32'(exp_v2[i]));
      chk("v2_sof", 32'(out_sof2), 32'((i % 4) == 0));
      chk("v2_eos", 32'(out_eos2), 32'((i % 4) == 3));
      chk("v2_underrun", 32'(underrun2), 32'(i == 7));
      if (i == 3) in_valid2 = 1'b0;
    end
    step();
    chk("v2_end_valid", 32'(out_valid2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
